uart_tx: RTL and testbench

- Serial transmitter of the UART path. It serialises one byte per frame onto the `tx` line.
- Frame format, in order: start bit (0), 8 data bits LSB-first, even parity bit, stop bit (1).
- Upstream logic hands bytes in through a valid/ready handshake.
- `tx` drives the `rx` input of the UART receiver, so the parity sense must match the receiver's check: XOR over data and parity = 0.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_if.sv | 11 +
 rtl/uart_baud_tick.sv | 26 ++
 rtl/uart_tx.sv | 128 ++++++++++++
 tb/tb_uart_tx.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and line-level constants for the transmitter and receiver.
package uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;
    localparam logic UART_IDLE_LVL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between upstream logic and the UART transmitter.
interface uart_tx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] tx_data;
    logic                      tx_valid;
    logic                      tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_end = (cnt == LAST);
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB-first, optional even parity, stop.
// Parity bit is present only when UART_TX_PARITY_EN is defined (define it to pair with the parity-checking receiver).
//
// state  | meaning
// IDLE   | line high, ready for a byte
// START  | driving start bit
// DATA   | shifting out data bits LSB-first
// PARITY | driving even parity bit
// STOP   | driving stop bit; done_t fires on exit
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus,
    output logic     tx,
    output logic     busy,
    output logic     done_t
);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    tx_state_e            state;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_q;
    logic                 ready_q;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    // Holding the counter clear in IDLE makes it start at zero on START entry;
    // every later transition happens on bit_end, where it wraps to zero anyway.
    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == IDLE),
        .bit_end (bit_end)
    );

    assign bus.tx_ready = ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shift_q  <= '0;
            tx       <= UART_IDLE_LVL;
            ready_q  <= 1'b1;
            busy     <= 1'b0;
            done_t   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            done_t <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.tx_valid && ready_q) begin
                        shift_q  <= bus.tx_data;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^bus.tx_data;
`endif
                        state    <= START;
                        tx       <= UART_START_LVL;
                        ready_q  <= 1'b0;
                        busy     <= 1'b1;
                    end else begin
                        tx      <= UART_IDLE_LVL;
                        ready_q <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        tx      <= shift_q[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= parity_q;
`else
                            state <= STOP;
                            tx    <= UART_STOP_LVL;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            tx      <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        tx    <= UART_STOP_LVL;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        tx      <= UART_IDLE_LVL;
                        ready_q <= 1'b1;
                        busy    <= 1'b0;
                        done_t  <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx      <= UART_IDLE_LVL;
                    ready_q <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4; frame length follows UART_TX_PARITY_EN.
module tb_uart_tx;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [10:0] A5_FRAME = 11'b1_0_10100101_0;
`else
    localparam int NB = 10;
    localparam logic [10:0] A5_FRAME = 11'b1_1_10100101_0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic tx, busy, done_t;
    int   errors = 0;
    int   checks = 0;

    uart_tx_if bus ();

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.slave),
        .tx     (tx),
        .busy   (busy),
        .done_t (done_t)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        f[0]    = 1'b0;
        f[8:1]  = b;
`ifdef UART_TX_PARITY_EN
        f[9]    = ^b;
`else
        f[9]    = 1'b1;
`endif
        f[10]   = 1'b1;
        return f;
    endfunction

    task automatic accept(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        while (bus.tx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_time", 32'(n < 200), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Called just after the accept edge; checks every cycle of the frame, decodes
    // it like a receiver sampling mid-bit, then checks the done_t cycle.
    task automatic check_frame(input string tag, input logic [7:0] b, input int inject,
                               output logic [10:0] got);
        logic [10:0] exp_f;
        exp_f = frame_of(b);
        got   = '1;
        for (int i = 0; i < NB * CPB; i++) begin
            @(negedge clk);
            if (i == inject) begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = 8'hFF;
            end
            chk({tag, "_tx"}, 32'(tx), 32'(exp_f[i / CPB]));
            if (i % CPB == CPB / 2) begin
                got[i / CPB] = tx;
                chk({tag, "_ready_low"}, 32'(bus.tx_ready), 32'd0);
                chk({tag, "_busy_high"}, 32'(busy), 32'd1);
                chk({tag, "_no_done"},   32'(done_t), 32'd0);
            end
        end
        chk({tag, "_rx_start"}, 32'(got[0]), 32'd0);
        chk({tag, "_rx_data"},  32'(got[8:1]), 32'(b));
`ifdef UART_TX_PARITY_EN
        chk({tag, "_rx_parity_err"}, 32'(^got[9:1]), 32'd0);
`endif
        chk({tag, "_rx_stop"}, 32'(got[NB - 1]), 32'd1);
        @(negedge clk);
        chk({tag, "_done"},     32'(done_t), 32'd1);
        chk({tag, "_ready_up"}, 32'(bus.tx_ready), 32'd1);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        chk({tag, "_idle_tx"},  32'(tx), 32'd1);
    endtask

    initial begin
        logic [10:0] got;
        int          bad;

        rst          = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tx",    32'(tx), 32'd1);
        chk("reset_ready", 32'(bus.tx_ready), 32'd1);
        chk("reset_busy",  32'(busy), 32'd0);
        chk("reset_done",  32'(done_t), 32'd0);
        rst = 1'b0;

        // Single byte 0xA5 with the serial image checked against a hand value
        accept(8'hA5);
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        check_frame("a5", 8'hA5, -1, got);
        chk("a5_frame", 32'(got[NB-1:0]), 32'(A5_FRAME[NB-1:0]));
        @(negedge clk);
        chk("a5_done_one_cycle", 32'(done_t), 32'd0);

        // Odd popcount
        accept(8'h07);
        bus.tx_valid = 1'b0;
        check_frame("x07", 8'h07, -1, got);
`ifdef UART_TX_PARITY_EN
        chk("x07_parity_bit", 32'(got[9]), 32'd1);
`endif

        // Back-to-back: valid held, second byte taken in the done_t cycle
        accept(8'h55);
        bus.tx_data = 8'hAA;
        check_frame("b2b_55", 8'h55, -1, got);
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
        check_frame("b2b_aa", 8'hAA, -1, got);
        @(negedge clk);
        chk("b2b_done_one_cycle", 32'(done_t), 32'd0);

        // 0xFF offered mid-DATA must wait for IDLE
        accept(8'h3C);
        bus.tx_valid = 1'b0;
        check_frame("busy_3c", 8'h3C, 5 * CPB + 1, got);
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
        check_frame("after_ff", 8'hFF, -1, got);

        // Reset during data bit 3 of 0xC3
        accept(8'hC3);
        bus.tx_valid = 1'b0;
        repeat (4 * CPB + 2) @(negedge clk);
        chk("abort_bit3_tx", 32'(tx), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_tx_high", 32'(tx), 32'd1);
        chk("abort_ready",   32'(bus.tx_ready), 32'd1);
        chk("abort_busy",    32'(busy), 32'd0);
        chk("abort_no_done", 32'(done_t), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done_t !== 1'b0 || tx !== 1'b1) bad++;
        end
        chk("abort_quiet_line", 32'(bad), 32'd0);

        accept(8'h81);
        bus.tx_valid = 1'b0;
        check_frame("x81", 8'h81, -1, got);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
